// File: rtl/dlx_fetch.sv
// dlx_fetch - instruction fetch unit for the DLX core.
//
// Generates sequential word-aligned fetch addresses, runs a hold-until-ack
// request handshake to instruction memory, and buffers returned words in a
// small prefetch FIFO whose head feeds the decoder.  A redirect flushes the
// FIFO and restarts fetch; a request still waiting for its ack at that time
// is completed on the bus (DROP state) and its data thrown away.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   imem_addr/imem_req    fetch address and request (registered)
//   imem_ack/imem_rdata   memory response and returned instruction word
//   i_data_read/id_pc     FIFO head instruction and its PC (0 when empty)
//   ID                    FIFO head valid (registered, FIFO not-empty)
//   id_ready              decoder accepts the head (pop on ID & id_ready)
//   redirect/redirect_pc  one-cycle restart strobe and new fetch address
module dlx_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] i_data_read,
  output logic        ID,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);
  localparam logic [2:0] LAST_C  = 3'(DEPTH - 1);

  // Advance a FIFO pointer, wrapping at DEPTH (need not be a power of two).
  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == LAST_C) ? 3'd0 : (p + 3'd1);
  endfunction

  state_t      state_r, state_next_s;
  logic [31:0] fetch_pc_r, fetch_pc_next_s;
  logic [31:0] addr_r, addr_next_s;
  logic        req_r;
  logic        id_valid_r;
  logic [3:0]  count_r, count_next_s, occ_pop_s;
  logic [2:0]  rd_ptr_r, wr_ptr_r;
  logic        pop_s, push_s, flush_s;
  logic [31:0] rpc_s;

  // Storage is sized for the largest legal DEPTH so 3-bit pointers index it exactly.
  logic [31:0] pc_mem_r    [8];
  logic [31:0] instr_mem_r [8];

  // Next-state, next-address and FIFO control decode.
  always_comb begin
    pop_s           = id_valid_r & id_ready;
    push_s          = 1'b0;
    flush_s         = 1'b0;
    state_next_s    = state_r;
    fetch_pc_next_s = fetch_pc_r;
    addr_next_s     = addr_r;
    rpc_s           = redirect_pc & 32'hFFFF_FFFC;
    // Occupancy after this cycle's pop, before any push.
    occ_pop_s       = count_r - {3'b000, pop_s};

    case (state_r)
      IDLE: begin
        if (redirect) begin
          flush_s         = 1'b1;
          fetch_pc_next_s = rpc_s;
          addr_next_s     = rpc_s;
          state_next_s    = REQ;
        end else if (occ_pop_s < DEPTH_C) begin
          addr_next_s  = fetch_pc_r;
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (imem_ack && redirect) begin
          flush_s         = 1'b1;
          fetch_pc_next_s = rpc_s;
          addr_next_s     = rpc_s;
          state_next_s    = REQ;
        end else if (imem_ack) begin
          push_s          = 1'b1;
          fetch_pc_next_s = fetch_pc_r + 32'd4;
          addr_next_s     = fetch_pc_r + 32'd4;
          // Keep requesting only if the pushed word still leaves a free slot.
          if ((occ_pop_s + 4'd1) < DEPTH_C) begin
            state_next_s = REQ;
          end else begin
            state_next_s = IDLE;
          end
        end else if (redirect) begin
          // Bus must hold the old address until ack; remember the new target.
          flush_s         = 1'b1;
          fetch_pc_next_s = rpc_s;
          state_next_s    = DROP;
        end else begin
          state_next_s = REQ;
        end
      end
      DROP: begin
        if (imem_ack && redirect) begin
          flush_s         = 1'b1;
          fetch_pc_next_s = rpc_s;
          addr_next_s     = rpc_s;
          state_next_s    = REQ;
        end else if (imem_ack) begin
          addr_next_s  = fetch_pc_r;
          state_next_s = REQ;
        end else if (redirect) begin
          flush_s         = 1'b1;
          fetch_pc_next_s = rpc_s;
          state_next_s    = DROP;
        end else begin
          state_next_s = DROP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    if (flush_s) begin
      count_next_s = 4'd0;
    end else begin
      count_next_s = occ_pop_s + {3'b000, push_s};
    end
  end

  // Fetch FSM, bus address/request and head-valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      addr_r     <= RESET_PC;
      req_r      <= 1'b0;
      id_valid_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      fetch_pc_r <= fetch_pc_next_s;
      addr_r     <= addr_next_s;
      req_r      <= (state_next_s != IDLE);
      id_valid_r <= (count_next_s != 4'd0);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r <= 3'd0;
      wr_ptr_r <= 3'd0;
      count_r  <= 4'd0;
    end else if (flush_s) begin
      rd_ptr_r <= 3'd0;
      wr_ptr_r <= 3'd0;
      count_r  <= 4'd0;
    end else begin
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      count_r <= count_next_s;
    end
  end

  // FIFO storage; contents are only observed while id_valid_r is set.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
      instr_mem_r[wr_ptr_r] <= imem_rdata;
    end
  end

  assign imem_addr   = addr_r;
  assign imem_req    = req_r;
  assign ID          = id_valid_r;
  assign i_data_read = id_valid_r ? instr_mem_r[rd_ptr_r] : 32'h0000_0000;
  assign id_pc       = id_valid_r ? pc_mem_r[rd_ptr_r]    : 32'h0000_0000;

endmodule
